data_mem_mmio: RTL
==================

Name: data_mem_mmio

Overview:
- Data-side memory stage that sits directly downstream of the processor core.
- Consumes the core's dAddress, dWriteData, MemRead and MemWrite, and produces the dReadData the core loads during its write-back step.
- Contains a word-addressed synchronous RAM at the data segment plus a small memory-mapped I/O window: LED register, cycle counter, store counter and sticky error status.
- Used by the processor testbench and top-level integration in place of a behavioural dReadData driver.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit RAM words.
- BASE_ADDR, 32'h10010000, byte address of RAM word 0.
- MMIO_BASE, 32'hFFFF0000, byte address of the MMIO window (4 registers, 16 bytes).

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  synchronous reset, active-low; sampled on posedge clk.
- MemRead  input  1  load request from the core.
- MemWrite  input  1  store request from the core.
- dAddress  input  32  byte address from the core.
- dWriteData  input  32  store data from the core.
- dReadData  output  32  registered load data to the core.
- misaligned  output  1  one-cycle pulse: the previous request had dAddress[1:0]!=0.
- addr_err  output  1  one-cycle pulse: the previous aligned request hit no mapped region.
- leds  output  8  LED register contents.

Behaviour:
- Reset (rst==0 at posedge):
  - dReadData=0, misaligned=0, addr_err=0, leds=0.
  - Cycle counter, store counter and status flags cleared.
  - RAM contents are NOT cleared.
  - Any request present in the reset cycle is ignored.
- Request: active when MemRead|MemWrite.
  - Accesses are word only.
  - RAM hit: BASE_ADDR <= dAddress < BASE_ADDR+4*DEPTH_WORDS. RAM index = (dAddress-BASE_ADDR)>>2.
  - MMIO hit: MMIO_BASE <= dAddress < MMIO_BASE+16.
- Store: MemWrite=1, aligned, RAM hit.
  - mem[idx] <= dWriteData on the same posedge.
  - Store counter increments by 1, wrapping at 2^32.
- Load: MemRead=1, aligned, hit.
  - dReadData <= addressed word on that posedge (latency 1 cycle).
  - dReadData holds its value while no load is requested.
- MemRead and MemWrite both 1: the store is performed and dReadData returns the newly written data (write-first).
- MMIO map (offset from MMIO_BASE):
  - 0x0 LED: R/W. A store writes dWriteData[7:0]. A load returns {24'b0, leds}.
  - 0x4 CYCLE: read-only. Free-running 32-bit counter, +1 every non-reset posedge, wraps to 0. A load returns the pre-increment value. Stores are ignored and raise no error.
  - 0x8 STORES: a load returns the store counter. Any store clears it to 0. MMIO stores never increment it.
  - 0xC STATUS: bit0 = sticky misaligned, bit1 = sticky addr_err, other bits 0. A store with dWriteData bit n =1 clears bit n (write-1-to-clear). If a set event and a clear for the same bit occur on the same edge, set wins.
- Misaligned request (dAddress[1:0]!=0):
  - No RAM/MMIO side effect; dReadData <= 0.
  - misaligned=1 for exactly the next cycle; STATUS bit0 set.
- Unmapped aligned request:
  - No side effect; dReadData <= 0.
  - addr_err=1 for exactly the next cycle; STATUS bit1 set.
- Misalignment takes priority over address decode: only misaligned pulses.
- Boundaries:
  - Last RAM word (BASE_ADDR+4*DEPTH_WORDS-4) is valid; +4*DEPTH_WORDS is unmapped.
  - MMIO_BASE+0x10 is unmapped.
  - Counters wrap silently.
- Back-to-back requests on consecutive cycles are supported with no bubbles.

Test Plan:
- Reset and cycle counter: hold rst=0 two cycles, then release; load 0xFFFF0004 three cycles later -> dReadData=2, leds=0, misaligned=0, addr_err=0.
- Store/load: store 0xDEADBEEF to 0x10010008, then load 0x10010008 next cycle -> dReadData=0xDEADBEEF one cycle after the load request; load of 0x10010FFC after storing 0x12345678 there -> 0x12345678.
- Simultaneous read/write: MemRead=MemWrite=1, dAddress=0x10010010, dWriteData=0xA5A5A5A5 -> dReadData=0xA5A5A5A5 next cycle; STORES reads 1 more than before.
- Errors: load 0x10010002 -> misaligned pulses 1 cycle, dReadData=0, STATUS=1; store to 0x10011000 -> addr_err pulses 1 cycle, no RAM change, STATUS=3; store 0x1 to 0xFFFF000C -> STATUS=2.
- MMIO: store 0x1FF to 0xFFFF0000 -> leds=0xFF; three RAM stores then load 0xFFFF0008 -> 3; store any value to 0xFFFF0008 -> next load returns 0.
- Reset mid-operation: assert rst=0 with MemWrite=1 at 0x10010000 and data 0x11111111 -> the word keeps its prior value, dReadData=0, STORES=0 after release.

Source files
------------

// File: rtl/data_mem_mmio.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_mmio
// Brief    : Data-side memory stage: word RAM plus LED/CYCLE/STORES/STATUS MMIO.
// Revision : 1.0 - initial release
// ============================================================================
module data_mem_mmio #(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h1001_0000,
    parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] dAddress,
    input  logic [31:0] dWriteData,
    output logic [31:0] dReadData,
    output logic        misaligned,
    output logic        addr_err,
    output logic [7:0]  leds
);

    localparam int          c_IDX_W    = $clog2(DEPTH_WORDS);
    localparam logic [32:0] c_RAM_END  = {1'b0, BASE_ADDR} + 33'(DEPTH_WORDS) * 33'd4;
    localparam logic [32:0] c_MMIO_END = {1'b0, MMIO_BASE} + 33'd16;

    localparam logic [1:0] c_SEL_LED    = 2'd0;
    localparam logic [1:0] c_SEL_CYCLE  = 2'd1;
    localparam logic [1:0] c_SEL_STORES = 2'd2;
    localparam logic [1:0] c_SEL_STATUS = 2'd3;

    logic [31:0] r_mem [DEPTH_WORDS];
    logic [31:0] r_cycle;
    logic [31:0] r_stores;
    logic [1:0]  r_status;
    logic [7:0]  r_leds;

    logic               w_req;
    logic               w_aligned;
    logic               w_ramHit;
    logic               w_mmioHit;
    logic [31:0]        w_ramOff;
    logic [31:0]        w_mmioOff;
    logic [c_IDX_W-1:0] w_ramIdx;
    logic [1:0]         w_sel;
    logic               w_misEvt;
    logic               w_errEvt;
    logic               w_ramWr;
    logic               w_mmioWr;
    logic [7:0]         w_ledsNext;
    logic [31:0]        w_storesNext;
    logic [1:0]         w_statusNext;
    logic [1:0]         w_statusClr;
    logic [31:0]        w_loadData;
    logic               w_unused;

    // Address decode; 33-bit compares keep the region ends from overflowing.
    assign w_req     = MemRead | MemWrite;
    assign w_aligned = (dAddress[1:0] == 2'b00);
    assign w_ramOff  = dAddress - BASE_ADDR;
    assign w_mmioOff = dAddress - MMIO_BASE;
    assign w_ramIdx  = w_ramOff[c_IDX_W+1:2];
    assign w_sel     = w_mmioOff[3:2];
    assign w_ramHit  = w_aligned && (dAddress >= BASE_ADDR) && ({1'b0, dAddress} < c_RAM_END);
    assign w_mmioHit = w_aligned && (dAddress >= MMIO_BASE) && ({1'b0, dAddress} < c_MMIO_END);
    assign w_misEvt  = w_req && !w_aligned;
    assign w_errEvt  = w_req && w_aligned && !w_ramHit && !w_mmioHit;
    assign w_ramWr   = MemWrite && w_ramHit;
    assign w_mmioWr  = MemWrite && w_mmioHit;
    assign w_unused  = ^{w_ramOff, w_mmioOff};

    always_comb begin
        w_ledsNext   = r_leds;
        w_storesNext = r_stores;
        w_statusClr  = 2'b00;
        if (w_mmioWr && (w_sel == c_SEL_LED)) begin
            w_ledsNext = dWriteData[7:0];
        end
        if (w_ramWr) begin
            w_storesNext = r_stores + 32'd1;
        end
        if (w_mmioWr && (w_sel == c_SEL_STORES)) begin
            w_storesNext = 32'd0;
        end
        if (w_mmioWr && (w_sel == c_SEL_STATUS)) begin
            w_statusClr = dWriteData[1:0];
        end
        // Set after clear so a same-edge error event wins over W1C.
        w_statusNext = (r_status & ~w_statusClr) | {w_errEvt, w_misEvt};
    end

    // Loads see the post-store value (write-first); CYCLE is pre-increment.
    always_comb begin
        w_loadData = 32'd0;
        if (w_ramHit) begin
            w_loadData = MemWrite ? dWriteData : r_mem[w_ramIdx];
        end else if (w_mmioHit) begin
            case (w_sel)
                c_SEL_LED:    w_loadData = {24'd0, w_ledsNext};
                c_SEL_CYCLE:  w_loadData = r_cycle;
                c_SEL_STORES: w_loadData = w_storesNext;
                c_SEL_STATUS: w_loadData = {30'd0, w_statusNext};
                default:      w_loadData = 32'd0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst && w_ramWr) begin
            r_mem[w_ramIdx] <= dWriteData;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cycle    <= 32'd0;
            r_stores   <= 32'd0;
            r_status   <= 2'b00;
            r_leds     <= 8'd0;
            dReadData  <= 32'd0;
            misaligned <= 1'b0;
            addr_err   <= 1'b0;
        end else begin
            r_cycle    <= r_cycle + 32'd1;
            r_stores   <= w_storesNext;
            r_status   <= w_statusNext;
            r_leds     <= w_ledsNext;
            misaligned <= w_misEvt;
            addr_err   <= w_errEvt;
            if (w_misEvt || w_errEvt) begin
                dReadData <= 32'd0;
            end else if (MemRead) begin
                dReadData <= w_loadData;
            end
        end
    end

    assign leds = r_leds;

endmodule
`default_nettype wire
